regfile_write_arbiter: RTL



---
 rtl/regfile_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/regfile_write_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file write path
package regfile_pkg;
    localparam int IDX_W    = 5;
    localparam int DATA_W   = 32;
    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_DBG  = 2;
    typedef enum logic {ARB, LOCKED} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot grant starting the search at ptr
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] grant
);
    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   rot;
    logic [NUM_REQ-1:0]   grot;
    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] gdbl;

    assign elig = req & mask;
    assign dbl  = {elig, elig} >> ptr;
    assign rot  = dbl[NUM_REQ-1:0];

    always_comb begin
        grot = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i]) begin
                grot    = '0;
                grot[i] = 1'b1;
            end
    end

    assign gdbl  = {grot, grot} << ptr;
    assign grant = gdbl[2*NUM_REQ-1:NUM_REQ];
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register-file write port with x0 filter and debug lock
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = regfile_pkg::DATA_W,
    parameter int IDX_W   = regfile_pkg::IDX_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*IDX_W-1:0]  req_index,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      flush,
    input  logic                      dbg_lock,
    output logic                      lock_ack,
    output logic                      rf_wr_en,
    output logic [IDX_W-1:0]          rf_wr_index,
    output logic [DATA_W-1:0]         rf_wr_data,
    output logic                      x0_drop
);
    import regfile_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] DBG_ONLY = NUM_REQ'(1) << (NUM_REQ - 1);

    arb_state_t         state, state_nx;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nx;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] grant;
    logic               hs;
    logic [PTR_W-1:0]   win;
    logic [IDX_W-1:0]   win_index;
    logic [DATA_W-1:0]  win_data;

    // grants are suppressed while in reset so nothing handshakes before a clean start
    assign mask = (!reset_n || flush) ? '0 : (state == LOCKED) ? DBG_ONLY : '1;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .mask (mask),
        .grant(grant)
    );

    assign req_ready = grant;
    assign hs        = |grant;
    assign lock_ack  = state == LOCKED;

    always_comb begin
        win       = '0;
        win_index = '0;
        win_data  = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) begin
                win       = PTR_W'(i);
                win_index = req_index[i*IDX_W +: IDX_W];
                win_data  = req_data[i*DATA_W +: DATA_W];
            end
    end

    always_comb begin
        state_nx  = dbg_lock ? LOCKED : ARB;
        rr_ptr_nx = (state == ARB && hs) ? ((win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1) : rr_ptr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ARB;
            rr_ptr <= '0;
        end else begin
            state  <= state_nx;
            rr_ptr <= rr_ptr_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_wr_en    <= 1'b0;
            x0_drop     <= 1'b0;
            rf_wr_index <= '0;
            rf_wr_data  <= '0;
        end else begin
            rf_wr_en <= hs && win_index != '0;
            x0_drop  <= hs && win_index == '0;
            if (hs && win_index != '0) begin
                rf_wr_index <= win_index;
                rf_wr_data  <= win_data;
            end
        end
    end
endmodule
